// File: rtl/pointwise_channel_accumulator_pkg.sv
// pointwise_channel_accumulator_pkg: shared Q16.16 constants and saturation helpers
package pointwise_channel_accumulator_pkg;
  localparam int FRAC_BITS_DEF = 16;
  localparam logic [31:0] ONE = 32'h0001_0000;
  localparam logic [31:0] MAX_POS = 32'h7FFF_FFFF;
  localparam logic [31:0] MAX_NEG = 32'h8000_0000;
  function automatic int idx_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
  function automatic logic [31:0] sat64(input logic [63:0] v);
    return (&v[63:31] || ~|v[63:31]) ? v[31:0] : v[63] ? MAX_NEG : MAX_POS;
  endfunction
  function automatic logic [31:0] sat33(input logic [32:0] v);
    return v[32] == v[31] ? v[31:0] : v[32] ? MAX_NEG : MAX_POS;
  endfunction
  function automatic logic [31:0] add_sat(input logic [31:0] a, input logic [31:0] b);
    return sat33({a[31], a} + {b[31], b});
  endfunction
endpackage

// File: rtl/pointwise_channel_accumulator_if.sv
// pointwise_channel_accumulator_if: pixel stream in, accumulated plane out
interface pointwise_channel_accumulator_if
  import pointwise_channel_accumulator_pkg::*;
#(
  parameter int NUM_CHANNELS = 3
);
  logic [31:0] Data_In;
  logic Valid_In;
  logic [31:0] Weight_In;
  logic [31:0] Bias_In;
  logic [31:0] Data_Out;
  logic Valid_Out;
  logic [idx_w(NUM_CHANNELS)-1:0] Channel_Idx;
  logic Frame_Done;
  modport master (
    output Data_In, Valid_In, Weight_In, Bias_In,
    input Data_Out, Valid_Out, Channel_Idx, Frame_Done
  );
  modport slave (
    input Data_In, Valid_In, Weight_In, Bias_In,
    output Data_Out, Valid_Out, Channel_Idx, Frame_Done
  );
endinterface

// File: rtl/pointwise_channel_accumulator_psum_ram.sv
// pointwise_channel_accumulator_psum_ram: simple dual-port partial-sum RAM with registered read
module pointwise_channel_accumulator_psum_ram #(
  parameter int DEPTH = 4,
  parameter int AW = 2
) (
  input logic clk,
  input logic we,
  input logic [AW-1:0] waddr,
  input logic [31:0] wdata,
  input logic re,
  input logic [AW-1:0] raddr,
  output logic [31:0] rdata
);
  logic [31:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/pointwise_channel_accumulator.sv
// pointwise_channel_accumulator: 1x1 conv, accumulates weighted channel planes, adds bias on last plane.
// Define POINTWISE_RELU_EN to clamp negative outputs to zero.
module pointwise_channel_accumulator
  import pointwise_channel_accumulator_pkg::*;
#(
  parameter int IMG_WIDTH = 150,
  parameter int IMG_HEIGHT = 150,
  parameter int NUM_CHANNELS = 3,
  parameter int FRAC_BITS = FRAC_BITS_DEF
) (
  input logic clk,
  input logic rst,
  pointwise_channel_accumulator_if.slave io
);
  localparam int DEPTH = IMG_WIDTH * IMG_HEIGHT;
  localparam int AW = idx_w(DEPTH);
  localparam int CW = idx_w(NUM_CHANNELS);
  if (DEPTH < 3 || NUM_CHANNELS < 1) begin : g_bad_cfg
    $error("plane needs >= 3 pixels and >= 1 channel");
  end
  logic [AW-1:0] pix, addr0, addr1;
  logic [CW-1:0] ch;
  logic last_pix, last_ch;
  logic v0, first0, last0, fin0, v1, zero1, last1, fin1;
  logic [31:0] prod0, prod1, bias0, bias1, rdata, prev, psum, total, out_val;
  logic [31:0] data_q;
  logic valid_q, done_q;
  logic signed [63:0] full;
  assign last_pix = pix == AW'(DEPTH - 1);
  assign last_ch = ch == CW'(NUM_CHANNELS - 1);
  assign full = ($signed({{32{io.Data_In[31]}}, io.Data_In}) *
                 $signed({{32{io.Weight_In[31]}}, io.Weight_In})) >>> FRAC_BITS;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      pix <= '0;
      ch <= '0;
    end else if (io.Valid_In) begin
      pix <= last_pix ? '0 : pix + 1'b1;
      if (last_pix) ch <= last_ch ? '0 : ch + 1'b1;
    end
  // bias is captured with its pixel so a new frame's bias cannot leak into the tail of the old one
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      v0 <= 1'b0;
      prod0 <= '0;
      bias0 <= '0;
      addr0 <= '0;
      first0 <= 1'b0;
      last0 <= 1'b0;
      fin0 <= 1'b0;
    end else begin
      v0 <= io.Valid_In;
      if (io.Valid_In) begin
        prod0 <= sat64(full);
        bias0 <= io.Bias_In;
        addr0 <= pix;
        first0 <= ch == '0;
        last0 <= last_ch;
        fin0 <= last_pix;
      end
    end
  pointwise_channel_accumulator_psum_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk(clk),
    .we(v1 && !last1),
    .waddr(addr1),
    .wdata(psum),
    .re(v0 && !first0),
    .raddr(addr0),
    .rdata(rdata)
  );
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      v1 <= 1'b0;
      prod1 <= '0;
      bias1 <= '0;
      addr1 <= '0;
      zero1 <= 1'b0;
      last1 <= 1'b0;
      fin1 <= 1'b0;
    end else begin
      v1 <= v0;
      if (v0) begin
        prod1 <= prod0;
        bias1 <= bias0;
        addr1 <= addr0;
        zero1 <= first0;
        last1 <= last0;
        fin1 <= fin0;
      end
    end
  assign prev = zero1 ? '0 : rdata;
  assign psum = add_sat(prev, prod1);
  assign total = last1 ? add_sat(psum, bias1) : psum;
`ifdef POINTWISE_RELU_EN
  assign out_val = total[31] ? '0 : total;
`else
  assign out_val = total;
`endif
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      data_q <= '0;
      valid_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      valid_q <= v1 && last1;
      done_q <= v1 && last1 && fin1;
      if (v1 && last1) data_q <= out_val;
    end
  assign io.Data_Out = data_q;
  assign io.Valid_Out = valid_q;
  assign io.Frame_Done = done_q;
  assign io.Channel_Idx = ch;
endmodule

// File: tb/tb_pointwise_channel_accumulator.sv
// tb_pointwise_channel_accumulator: directed plan plus random frames against a plain-arithmetic model.
// Unit a is 2x2 with 2 channels, unit b is 2x2 with a single channel.
module tb_pointwise_channel_accumulator;
  import pointwise_channel_accumulator_pkg::*;
  localparam int NPIX = 4;
  typedef struct { logic [31:0] data; logic fd; int due; } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int cyc = 0;
  int vectors = 0;
  int miscompares = 0;
  longint acc [2][NPIX];
  int pix [2] = '{0, 0};
  int ch [2] = '{0, 0};
  int nch [2] = '{2, 1};
  exp_t qa [$];
  exp_t qb [$];
  logic [31:0] seen_a [$];
  logic [31:0] seen_b [$];
  logic [31:0] basic [4] = '{32'h0004_0000, 32'h0006_0000, 32'h0008_0000, 32'h000A_0000};
  logic ev_a, ev_b;
  pointwise_channel_accumulator_if #(.NUM_CHANNELS(2)) ia ();
  pointwise_channel_accumulator_if #(.NUM_CHANNELS(1)) ib ();
  pointwise_channel_accumulator #(.IMG_WIDTH(2), .IMG_HEIGHT(2), .NUM_CHANNELS(2), .FRAC_BITS(16)) dut_a (
    .clk(clk), .rst(rst), .io(ia.slave));
  pointwise_channel_accumulator #(.IMG_WIDTH(2), .IMG_HEIGHT(2), .NUM_CHANNELS(1), .FRAC_BITS(16)) dut_b (
    .clk(clk), .rst(rst), .io(ib.slave));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask
  function automatic longint lim(input longint v);
    return v > 64'sh7FFF_FFFF ? 64'sh7FFF_FFFF : v < -64'sh8000_0000 ? -64'sh8000_0000 : v;
  endfunction
  function automatic logic [31:0] rv();
    logic [31:0] r;
    r = $urandom;
    return $urandom_range(0, 3) == 0 ? r : {{13{r[18]}}, r[18:0]};
  endfunction
  always @(negedge clk) begin
    if (!rst) begin
      check("rst_a", {ia.Data_Out, ia.Valid_Out, ia.Frame_Done, ia.Channel_Idx}, '0);
      check("rst_b", {ib.Data_Out, ib.Valid_Out, ib.Frame_Done, ib.Channel_Idx}, '0);
    end else begin
      ev_a = qa.size() > 0 && qa[0].due == cyc;
      ev_b = qb.size() > 0 && qb[0].due == cyc;
      check("valid_a", ia.Valid_Out, ev_a);
      check("valid_b", ib.Valid_Out, ev_b);
      if (ia.Valid_Out) seen_a.push_back(ia.Data_Out);
      if (ib.Valid_Out) seen_b.push_back(ib.Data_Out);
      if (ev_a) begin
        check("data_a", ia.Data_Out, qa[0].data);
        check("done_a", ia.Frame_Done, qa[0].fd);
        void'(qa.pop_front());
      end else check("done_a", ia.Frame_Done, 0);
      if (ev_b) begin
        check("data_b", ib.Data_Out, qb[0].data);
        check("done_b", ib.Frame_Done, qb[0].fd);
        void'(qb.pop_front());
      end else check("done_b", ib.Frame_Done, 0);
    end
  end
  task automatic idle();
    @(posedge clk);
    #1;
    ia.Valid_In = 1'b0;
    ib.Valid_In = 1'b0;
  endtask
  task automatic drive(input int u, input logic [31:0] d, input logic [31:0] w, input logic [31:0] b);
    longint p, s;
    exp_t e;
    @(posedge clk);
    #1;
    if (u == 0) begin
      ia.Valid_In = 1'b1; ia.Data_In = d; ia.Weight_In = w; ia.Bias_In = b; ib.Valid_In = 1'b0;
      check("chidx_a", 64'(ia.Channel_Idx), 64'(ch[0]));
    end else begin
      ib.Valid_In = 1'b1; ib.Data_In = d; ib.Weight_In = w; ib.Bias_In = b; ia.Valid_In = 1'b0;
      check("chidx_b", 64'(ib.Channel_Idx), 64'(ch[1]));
    end
    p = lim((longint'($signed(d)) * longint'($signed(w))) >>> 16);
    s = ch[u] == 0 ? p : lim(acc[u][pix[u]] + p);
    if (ch[u] == nch[u] - 1) begin
      s = lim(s + longint'($signed(b)));
`ifdef POINTWISE_RELU_EN
      if (s < 0) s = 0;
`endif
      e.data = s[31:0];
      e.fd = pix[u] == NPIX - 1;
      e.due = cyc + 3;
      if (u == 0) qa.push_back(e); else qb.push_back(e);
    end else acc[u][pix[u]] = s;
    pix[u]++;
    if (pix[u] == NPIX) begin
      pix[u] = 0;
      ch[u] = (ch[u] + 1) % nch[u];
    end
  endtask
  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    ia.Valid_In = 1'b1;
    ib.Valid_In = 1'b1;
    qa.delete();
    qb.delete();
    pix = '{0, 0};
    ch = '{0, 0};
    repeat (2) @(posedge clk);
    #1;
    ia.Valid_In = 1'b0;
    ib.Valid_In = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask
  task automatic basic_frame(input bit gap, input int stop_after);
    int n;
    n = 0;
    for (int c = 0; c < 2; c++)
      for (int p = 0; p < NPIX; p++) begin
        if (n == stop_after) return;
        drive(0, c == 0 ? 32'(p + 1) << 16 : 32'h0002_0000, c == 0 ? 32'h0002_0000 : 32'h0000_8000, ONE);
        n++;
        if (gap) idle();
      end
  endtask
  task automatic check_basic(input string tag);
    check({tag, "_count"}, seen_a.size(), 4);
    for (int i = 0; i < 4; i++) check(tag, i < seen_a.size() ? seen_a[i] : 32'hx, basic[i]);
  endtask
  task automatic rand_frame(input int u);
    logic [31:0] b, w;
    b = rv();
    for (int c = 0; c < nch[u]; c++) begin
      w = rv();
      for (int p = 0; p < NPIX; p++) begin
        drive(u, rv(), w, b);
        if ($urandom_range(0, 2) == 0) idle();
      end
    end
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    ia.Valid_In = 1'b0; ia.Data_In = '0; ia.Weight_In = '0; ia.Bias_In = '0;
    ib.Valid_In = 1'b0; ib.Data_In = '0; ib.Weight_In = '0; ib.Bias_In = '0;
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    basic_frame(1'b0, 8);
    repeat (6) idle();
    check_basic("basic");
    seen_a.delete();
    basic_frame(1'b1, 8);
    repeat (6) idle();
    check_basic("gapped");
    drive(1, 32'h7FFF_0000, 32'h7FFF_0000, ONE);
    drive(1, 32'h7FFF_0000, MAX_NEG, 32'h0);
    drive(1, 32'hFFFF_0000, ONE, 32'h0);
    drive(1, 32'h0, 32'h0, 32'h0);
    repeat (6) idle();
    check("sat_pos", seen_b[0], MAX_POS);
`ifdef POINTWISE_RELU_EN
    check("sat_neg", seen_b[1], 32'h0);
    check("relu", seen_b[2], 32'h0);
`else
    check("sat_neg", seen_b[1], MAX_NEG);
    check("relu", seen_b[2], 32'hFFFF_0000);
`endif
    basic_frame(1'b0, 6);
    do_reset();
    seen_a.delete();
    basic_frame(1'b0, 8);
    repeat (6) idle();
    check_basic("midreset");
    for (int i = 0; i < 8; i++) rand_frame(0);
    for (int i = 0; i < 12; i++) rand_frame(1);
    repeat (8) idle();
    check("drain_a", qa.size(), 0);
    check("drain_b", qb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/pointwise_channel_accumulator.md
Name: pointwise_channel_accumulator

Overview:
- Stage directly downstream of the stride-2 1x1 decimator.
- Consumes the decimated pixel stream one input-channel plane at a time and multiplies each pixel by that plane's 1x1 weight.
- Accumulates the weighted pixels across all input channels in a per-pixel partial-sum RAM.
- On the last channel plane, adds bias and emits one output-channel plane in raster order.

Parameters:
- IMG_WIDTH, 150, decimated plane width in pixels.
- IMG_HEIGHT, 150, decimated plane height in pixels.
- NUM_CHANNELS, 3, input channel planes per output plane (>=1).
- FRAC_BITS, 16, fractional bits of signed fixed-point data, weight and bias.

Ports:
- clk  input  1  clock, all logic on rising edge.
- rst  input  1  asynchronous active-low reset.
- Data_In  input  32  signed fixed-point pixel.
- Valid_In  input  1  Data_In qualifier; any duty cycle, gaps allowed.
- Weight_In  input  32  signed weight for the current channel plane; held stable for the whole plane.
- Bias_In  input  32  signed bias; held stable during the last plane.
- Data_Out  output  32  signed accumulated pixel.
- Valid_Out  output  1  Data_Out qualifier, one cycle per output pixel.
- Channel_Idx  output  clog2(NUM_CHANNELS)  channel plane currently being consumed.
- Frame_Done  output  1  one-cycle pulse together with the last Valid_Out of a plane.

Behaviour:
- Reset values: Data_Out=0, Valid_Out=0, Frame_Done=0, Channel_Idx=0.
- Reset also clears the pixel counter, the channel counter and all pipeline valid bits. RAM contents are not cleared.
- Pixel counter: 0..IMG_WIDTH*IMG_HEIGHT-1, advances on each Valid_In.
- At the last pixel the pixel counter wraps to 0 and the channel counter increments.
- At channel NUM_CHANNELS-1 the channel counter wraps to 0, which starts the next frame.
- Pipeline, three stages, each advances only with its valid bit:
  - S0: 64-bit signed product Data_In*Weight_In, arithmetic shift right by FRAC_BITS, saturate to 32 bits. Address and channel are registered alongside.
  - S1: synchronous RAM read at the address. Skipped when channel==0; the read value is treated as 0.
  - S2: sum = prev + prod. On the last channel, sum additionally includes Bias_In.
    - Every add is 33-bit, then saturated to [0x80000000, 0x7FFFFFFF].
    - Not last channel: write sum to the RAM.
    - Last channel: drive Data_Out and Valid_Out, with no RAM write.
- Latency: Valid_Out asserts 3 cycles after the Valid_In of the corresponding last-channel pixel.
- Throughput: one pixel per cycle.
- NUM_CHANNELS==1: output = sat(prod + bias) and the RAM is never used.
- Read-after-write: consecutive pixels hit distinct addresses. IMG_WIDTH*IMG_HEIGHT>=3 is a required, assertion-checked constraint, so no bypass path is needed.
- Valid_Out is deasserted in every cycle without an S2 last-channel beat. Data_Out holds its last value.
- Valid_In during reset is ignored.
- Reset mid-frame:
  - In-flight beats are discarded.
  - The next Valid_In is pixel 0 of channel 0.
  - Stale RAM contents are harmless because channel 0 overwrites them.
- Frame_Done accompanies the Valid_Out of pixel IMG_WIDTH*IMG_HEIGHT-1.

Optional Feature:
- Macro: POINTWISE_RELU_EN.
- Defined: the S2 output path clamps negative results to 0 before Data_Out. Partial sums stored in RAM are not clamped.
- Undefined: Data_Out is the raw saturated sum.

Decomposition:
- Shared package:
  - FRAC_BITS default.
  - Fixed-point saturation function (64->32 and 33->32).
  - Q-format constants ONE=0x00010000, MAX_POS=0x7FFFFFFF, MAX_NEG=0x80000000.
- One sub-module, psum_ram: simple dual-port, one write port, one registered read port, depth IMG_WIDTH*IMG_HEIGHT, 32-bit. Infers block RAM.

Test Plan:
- Basic accumulation. Setup: W=H=2, C=2, bias 1.0.
  - ch0: weight 2.0, pixels 1.0,2.0,3.0,4.0.
  - ch1: weight 0.5, pixels 2.0 x4.
  - Required: Data_Out 0x00040000, 0x00060000, 0x00080000, 0x000A0000.
  - Each Valid_Out arrives 3 cycles after its ch1 Valid_In. Frame_Done pulses with the 4th.
- Gapped input: same stimulus as above with Valid_In low on alternate cycles.
  - Required: identical outputs, no extra Valid_Out, Channel_Idx 0->1->0.
- Saturation: C=1, weight 0x7FFF0000, pixel 0x7FFF0000, bias 1.0.
  - Required: Data_Out 0x7FFFFFFF.
  - With weight 0x80000000, pixel 0x7FFF0000, bias 0: required Data_Out 0x80000000.
- ReLU: C=1, weight 1.0, pixel 0xFFFF0000 (-1.0), bias 0.
  - POINTWISE_RELU_EN defined: Data_Out 0.
  - Undefined: Data_Out 0xFFFF0000.
- Reset mid-frame: assert rst after 2 ch1 pixels, then replay the full basic frame.
  - Required: exactly 4 outputs equal to the basic results.
  - No Valid_Out from pre-reset beats. All outputs read 0 during reset.
